// File: rtl/execute_muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Optional early-out divide is enabled by defining EXECUTE_MULDIV_EARLY_OUT_EN.
package execute_muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/execute_muldiv_step.sv
// One iteration of the multiply/divide datapath: BITS_PER_CYC shift-add or
// restoring-subtract bits on a {hi, lo} 2*XLEN accumulator.
module execute_muldiv_step #(
  parameter int XLEN         = 32,
  parameter int BITS_PER_CYC = 1
) (
  input  logic              i_is_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] w_acc;
  logic [XLEN:0]     w_tmp;
  logic [XLEN:0]     w_sum;

  // Multiply: hi accumulates the multiplicand, lo holds the unretired multiplier bits.
  // Divide: hi is the partial remainder, lo shifts the dividend out and quotient in.
  always_comb begin
    w_acc = i_acc;
    w_tmp = '0;
    w_sum = '0;
    for (int k = 0; k < BITS_PER_CYC; k++) begin
      if (i_is_div) begin
        w_tmp = {w_acc[2*XLEN-1:XLEN], w_acc[XLEN-1]};
        w_acc[XLEN-1:0] = {w_acc[XLEN-2:0], 1'b0};
        if (w_tmp >= {1'b0, i_opnd}) begin
          w_acc[2*XLEN-1:XLEN] = w_tmp[XLEN-1:0] - i_opnd;
          w_acc[0] = 1'b1;
        end else begin
          w_acc[2*XLEN-1:XLEN] = w_tmp[XLEN-1:0];
        end
      end else begin
        w_sum = {1'b0, w_acc[2*XLEN-1:XLEN]} + (w_acc[0] ? {1'b0, i_opnd} : '0);
        w_acc = {w_sum, w_acc[XLEN-1:1]};
      end
    end
    o_acc = w_acc;
  end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit; one op at a time, result pulsed for one cycle.
// Define EXECUTE_MULDIV_EARLY_OUT_EN to finish divides with |dividend| < |divisor| at once.
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BITS_PER_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [2:0]      id_funct3,
  input  logic [XLEN-1:0] id_dat_a,
  input  logic [XLEN-1:0] id_dat_b,
  input  logic [4:0]      id_dst,
  input  logic            ex_flush,
  output logic            ex_stall,
  output logic            ma_valid,
  output logic [XLEN-1:0] ma_dat,
  output logic [4:0]      ma_dst
);

  localparam int N     = XLEN / BITS_PER_CYC;
  localparam int CNT_W = $clog2(N);

  muldiv_state_e     r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic [2:0]        r_f3;
  logic [4:0]        r_dst;
  logic              r_neg_res;
  logic              r_neg_rem;
  logic [XLEN-1:0]   r_ma_dat;
  logic [4:0]        r_ma_dst;

  muldiv_op_e        w_op;
  logic              w_is_div;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_early;
  logic              w_special;
  logic [XLEN-1:0]   w_spec_res;
  logic [2*XLEN-1:0] w_step_acc;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign w_op       = muldiv_op_e'(id_funct3);
  assign w_is_div   = op_is_div(w_op);
  assign w_a_signed = (w_op == OP_MULH) | (w_op == OP_MULHSU) | (w_op == OP_DIV) | (w_op == OP_REM);
  assign w_b_signed = (w_op == OP_MULH) | (w_op == OP_DIV) | (w_op == OP_REM);
  assign w_neg_a    = w_a_signed & id_dat_a[XLEN-1];
  assign w_neg_b    = w_b_signed & id_dat_b[XLEN-1];
  assign w_mag_a    = w_neg_a ? -id_dat_a : id_dat_a;
  assign w_mag_b    = w_neg_b ? -id_dat_b : id_dat_b;

  assign w_div_zero = w_is_div & (id_dat_b == '0);
  assign w_ovf      = ((w_op == OP_DIV) | (w_op == OP_REM)) &
                      (id_dat_a == {1'b1, {(XLEN-1){1'b0}}}) & (id_dat_b == '1);
`ifdef EXECUTE_MULDIV_EARLY_OUT_EN
  assign w_early    = w_is_div & (id_dat_b != '0) & (w_mag_a < w_mag_b);
`else
  assign w_early    = 1'b0;
`endif
  assign w_special  = w_div_zero | w_ovf | w_early;

  // funct3[1] separates REM/REMU from DIV/DIVU on the special path.
  always_comb begin
    w_spec_res = '0;
    if (w_div_zero) begin
      w_spec_res = id_funct3[1] ? id_dat_a : '1;
    end else if (w_ovf) begin
      w_spec_res = id_funct3[1] ? '0 : id_dat_a;
    end else if (w_early) begin
      w_spec_res = id_funct3[1] ? id_dat_a : '0;
    end
  end

  execute_muldiv_step #(
    .XLEN         (XLEN),
    .BITS_PER_CYC (BITS_PER_CYC)
  ) u_step (
    .i_is_div (r_f3[2]),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step_acc)
  );

  assign w_prod    = r_neg_res ? -r_acc : r_acc;
  assign w_quo     = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem     = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_fix_res = r_f3[2] ? (r_f3[1] ? w_rem : w_quo)
                             : ((r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_f3      <= '0;
      r_dst     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_ma_dat  <= '0;
      r_ma_dst  <= '0;
    end else if (ex_flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (id_valid) begin
            r_f3      <= id_funct3;
            r_dst     <= id_dst;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
            r_acc     <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_opnd    <= w_is_div ? w_mag_b : w_mag_a;
            r_cnt     <= '0;
            if (w_special) begin
              r_ma_dat <= w_spec_res;
              r_ma_dst <= id_dst;
              r_state  <= DONE;
            end else begin
              r_state  <= CALC;
            end
          end
        end
        CALC: begin
          r_acc <= w_step_acc;
          if (r_cnt == CNT_W'(N-1)) begin
            r_cnt   <= '0;
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        FIX: begin
          r_ma_dat <= w_fix_res;
          r_ma_dst <= r_dst;
          r_state  <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // A flush landing in DONE kills the pulse in the same cycle.
  assign ma_valid = (r_state == DONE) & ~ex_flush;
  assign ma_dat   = r_ma_dat;
  assign ma_dst   = r_ma_dst;
  assign ex_stall = ~rst & (((r_state == IDLE) & id_valid) | (r_state == CALC) | (r_state == FIX));

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: driver pushes expected {dst, data, cycle}, monitor pops on ma_valid.
// Latency expectations follow EXECUTE_MULDIV_EARLY_OUT_EN when defined.
module tb_execute_muldiv;

  localparam int XLEN = 32;
  localparam int LAT  = 34;
`ifdef EXECUTE_MULDIV_EARLY_OUT_EN
  localparam int LAT_EO = 1;
`else
  localparam int LAT_EO = LAT;
`endif
  localparam int W = 5 + XLEN + 32;

  logic            clk;
  logic            rst;
  logic            id_valid;
  logic [2:0]      id_funct3;
  logic [XLEN-1:0] id_dat_a;
  logic [XLEN-1:0] id_dat_b;
  logic [4:0]      id_dst;
  logic            ex_flush;
  logic            ex_stall;
  logic            ma_valid;
  logic [XLEN-1:0] ma_dat;
  logic [4:0]      ma_dst;

  logic [W-1:0] exp_q[$];
  int           cyc;
  int           checks;
  int           errors;

  execute_muldiv #(.XLEN(XLEN), .BITS_PER_CYC(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_funct3 (id_funct3),
    .id_dat_a  (id_dat_a),
    .id_dat_b  (id_dat_b),
    .id_dst    (id_dst),
    .ex_flush  (ex_flush),
    .ex_stall  (ex_stall),
    .ma_valid  (ma_valid),
    .ma_dat    (ma_dat),
    .ma_dst    (ma_dst)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && ma_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got ma_valid=1 dat=0x%08h expected no pulse (cycle %0d)", ma_dat, cyc);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("ma_dat", ma_dat, e[63:32]);
        check("ma_dst", 32'(ma_dst), 32'(e[68:64]));
        check("latency_cycle", cyc, e[31:0]);
      end
    end
  end

  // driver: present op in the current cycle, then track stall until the result drains
  task automatic run_op(input bit sync, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] dst,
                        input logic [31:0] exp_dat, input int lat);
    int acc;
    if (sync) @(negedge clk);
    acc       = cyc;
    id_valid  = 1'b1;
    id_funct3 = f3;
    id_dat_a  = a;
    id_dat_b  = b;
    id_dst    = dst;
    exp_q.push_back({dst, exp_dat, 32'(acc + lat)});
    #1 check("stall_accept", 32'(ex_stall), 32'd1);
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      id_valid = 1'b0;
      #1;
      check("stall_track", 32'(ex_stall), 32'(i < lat));
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got no ma_valid expected one at cycle %0d", acc + lat);
      exp_q.delete();
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    id_valid  = 1'b1;
    id_funct3 = '0;
    id_dat_a  = '0;
    id_dat_b  = '0;
    id_dst    = '0;
    ex_flush  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(ex_stall), 32'd0);
    check("rst_valid", 32'(ma_valid), 32'd0);
    check("rst_dat", ma_dat, 32'd0);
    check("rst_dst", 32'(ma_dst), 32'd0);
    id_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);

    // multiply
    run_op(1, 3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, LAT);
    run_op(1, 3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, LAT);
    run_op(1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, LAT);
    run_op(1, 3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, LAT);
    run_op(1, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'h00000000, LAT);
    // divide
    run_op(1, 3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, LAT);
    run_op(1, 3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, LAT);
    run_op(1, 3'b101, 32'd100,      32'd7,        5'd12, 32'd14,       LAT);
    run_op(1, 3'b111, 32'd100,      32'd7,        5'd13, 32'd2,        LAT);
    run_op(1, 3'b100, 32'h80000000, 32'd2,        5'd14, 32'hC0000000, LAT);
    run_op(1, 3'b100, 32'd7,        32'hFFFFFFFD, 5'd15, 32'hFFFFFFFE, LAT);
    run_op(1, 3'b110, 32'd7,        32'hFFFFFFFD, 5'd16, 32'd1,        LAT);
    // divide-by-zero and signed overflow
    run_op(1, 3'b101, 32'd5,        32'd0,        5'd17, 32'hFFFFFFFF, 1);
    run_op(1, 3'b110, 32'd5,        32'd0,        5'd18, 32'd5,        1);
    run_op(1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1);
    run_op(1, 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0,        1);
    // small dividend
    run_op(1, 3'b101, 32'd3,        32'd9,        5'd21, 32'd0,        LAT_EO);
    run_op(1, 3'b111, 32'd3,        32'd9,        5'd22, 32'd3,        LAT_EO);
    run_op(1, 3'b110, 32'hFFFFFFFD, 32'd9,        5'd23, 32'hFFFFFFFD, LAT_EO);
    run_op(1, 3'b100, 32'hFFFFFFFD, 32'd9,        5'd24, 32'd0,        LAT_EO);

    // flush a divide at cycle 10, new multiply accepted at cycle 11
    @(negedge clk);
    id_valid  = 1'b1;
    id_funct3 = 3'b101;
    id_dat_a  = 32'd100;
    id_dat_b  = 32'd7;
    id_dst    = 5'd25;
    repeat (10) begin
      @(negedge clk);
      id_valid = 1'b0;
    end
    ex_flush = 1'b1;
    #1 check("flush_stall_calc", 32'(ex_stall), 32'd1);
    @(negedge clk);
    ex_flush = 1'b0;
    #1 check("flush_idle_stall", 32'(ex_stall), 32'd0);
    run_op(0, 3'b000, 32'd3, 32'd4, 5'd26, 32'd12, LAT);

    // reset in the middle of a multiply
    @(negedge clk);
    id_valid  = 1'b1;
    id_funct3 = 3'b000;
    id_dat_a  = 32'd9;
    id_dat_b  = 32'd9;
    id_dst    = 5'd27;
    repeat (15) begin
      @(negedge clk);
      id_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(ma_valid), 32'd0);
    check("midrst_dat", ma_dat, 32'd0);
    check("midrst_dst", 32'(ma_dst), 32'd0);
    check("midrst_stall", 32'(ex_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    #1 check("post_rst_stall", 32'(ex_stall), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
Iterative RV32M multiply/divide unit in the execute stage, alongside the single-cycle ALU. It accepts one M-extension op at a time from decode and stalls the front of the pipeline while computing. It presents the result to memory-access for exactly one cycle. Width and radix are parametrised, so the same block serves future 64-bit or faster configurations.

Parameters:
XLEN, 32, operand/result width; must be a power of 2 and at least 8.
BITS_PER_CYC, 1, quotient/multiplier bits retired per iteration; one of 1, 2, 4; must divide XLEN.

Ports:
clk  input  1  core clock.
rst  input  1  asynchronous active-high reset.
id_valid  input  1  decode presents an M-extension op (opcode OP, funct7 0000001).
id_funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
id_dat_a  input  XLEN  rs1 value, post-forwarding.
id_dat_b  input  XLEN  rs2 value, post-forwarding.
id_dst  input  5  rd pointer.
ex_flush  input  1  kill the in-flight op (branch flush).
ex_stall  output  1  hold fetch/decode; the op is not yet complete.
ma_valid  output  1  result valid, one-cycle pulse.
ma_dat  output  XLEN  result.
ma_dst  output  5  rd of the result.

Behaviour:
- Reset: state IDLE; ma_valid=0, ma_dat=0, ma_dst=0, internal counter/accumulators=0. ex_stall is forced 0 while rst=1.
- Let N = XLEN/BITS_PER_CYC. States: IDLE, CALC, FIX, DONE.
- IDLE with id_valid=1: capture operands, funct3, dst (cycle 0). Operands are converted to magnitudes per signedness; result sign is recorded.
  - Special case, next state DONE directly: div/rem by zero gives quotient all-ones and remainder = dividend. Signed overflow (-2^(XLEN-1) / -1) gives quotient = dividend and remainder 0.
  - Otherwise next state CALC with counter=0.
- CALC: one step per cycle, BITS_PER_CYC bits each.
  - Mul: shift-add into a 2*XLEN accumulator.
  - Div: restoring divide.
  - Counter increments each step; after step N-1, go to FIX.
- FIX: apply sign correction (two's complement of product/quotient/remainder as required). Select low or high half by funct3. Register into ma_dat/ma_dst, then go to DONE.
- DONE: ma_valid=1 for this cycle only, then IDLE. ma_dat/ma_dst hold until the next DONE.
- Latency: general path ma_valid at cycle N+2 after acceptance (34 for the defaults); special case at cycle 1.
- ex_stall = (state==IDLE & id_valid) | state==CALC | state==FIX. It is low in DONE, so the pipeline advances with the result.
- id_valid outside IDLE is ignored; upstream holds it under stall. An op is accepted again in the cycle after DONE at the earliest.
- ex_flush=1 in any state: next state IDLE, no ma_valid pulse, counter cleared. In IDLE, flush blocks acceptance that cycle. Flush in DONE suppresses ma_valid.
- Remainder sign follows the dividend. Quotient sign is the XOR of the operand signs. MULHSU treats rs1 signed and rs2 unsigned.
- Reset asserted mid-operation aborts immediately; no ma_valid after release.

Optional Feature:
EXECUTE_MULDIV_EARLY_OUT_EN
- Defined: for DIV/DIVU/REM/REMU where |dividend| < |divisor| (divisor nonzero), take the special-case path. Quotient 0, remainder = dividend; ma_valid at cycle 1.
- Undefined: these ops take the full N+2 cycles.
- Results are identical either way; only latency differs.

Decomposition:
- utils_top package additions:
  - muldiv_op_e enum for the eight funct3 codes.
  - FUNCT7_MULDIV = 7'b0000001.
  - muldiv_state_e {IDLE, CALC, FIX, DONE}.
- Sub-module execute_muldiv_step: combinational single iteration (BITS_PER_CYC-bit shift-add or restoring-subtract), parametrised by XLEN and BITS_PER_CYC.

Test Plan:
1. MUL 7 * 0xFFFFFFFD (-3), dst=5 -> ex_stall high cycles 0..33; ma_valid at cycle 34 with ma_dat=0xFFFFFFEB, ma_dst=5.
2. MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
4. DIVU 5/0 -> ma_valid at cycle 1, 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
5. DIV started, ex_flush at cycle 10 -> IDLE at cycle 11, no ma_valid. A new MUL 3*4 accepted at cycle 11 -> 12 at cycle 45.
6. rst pulsed at cycle 15 of a MUL -> ma_valid/ma_dat/ex_stall 0 immediately, no pulse after release. With EXECUTE_MULDIV_EARLY_OUT_EN, DIVU 3/9 -> 0 at cycle 1.
